// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: divides clk to a centisecond tick and keeps SS.cc as four BCD digits.
// Clear has priority over run; pausing keeps the partial prescaler count.
module stopwatch_time_counter #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_regs,
    input  logic        count_enabled,
    output logic [3:0]  cs_ones,
    output logic [3:0]  cs_tens,
    output logic [3:0]  s_ones,
    output logic [3:0]  s_tens,
    output logic [15:0] time_bcd,
    output logic        tick,
    output logic        wrap
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    digit_q [4];
    logic [3:0]    digit_d [4];
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          carry;

    always_comb begin
        presc_d = presc_q;
        digit_d = digit_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        carry   = 1'b0;
        if (init_regs) begin
            presc_d = '0;
            for (int i = 0; i < 4; i++) begin
                digit_d[i] = 4'd0;
            end
        end else if (count_enabled) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                // Ripple the +1 through the digits; a carry out of the top digit is a wrap.
                carry   = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (carry) begin
                        if (digit_q[i] == 4'd9) begin
                            digit_d[i] = 4'd0;
                        end else begin
                            digit_d[i] = digit_q[i] + 4'd1;
                            carry      = 1'b0;
                        end
                    end
                end
                wrap_d = carry;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 4'd0;
            end
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cs_ones  = digit_q[0];
    assign cs_tens  = digit_q[1];
    assign s_ones   = digit_q[2];
    assign s_tens   = digit_q[3];
    assign time_bcd = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
    assign tick     = tick_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed plus randomized checks of the stopwatch counter against an elapsed-centisecond model.
module tb_stopwatch_time_counter;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_regs = 1'b0;
    logic        count_enabled = 1'b0;
    logic [3:0]  cs_ones, cs_tens, s_ones, s_tens;
    logic [15:0] time_bcd;
    logic        tick, wrap;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed hundredths as a plain integer plus enabled-edge phase.
    int m_cs = 0;
    int m_phase = 0;
    bit m_tick = 1'b0;
    bit m_wrap = 1'b0;
    int cyc = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;
    int last_tick_cyc = -1;

    stopwatch_time_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .cs_ones       (cs_ones),
        .cs_tens       (cs_tens),
        .s_ones        (s_ones),
        .s_tens        (s_tens),
        .time_bcd      (time_bcd),
        .tick          (tick),
        .wrap          (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cs = 0;
        m_phase = 0;
        m_tick = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bcd"}, time_bcd, to_bcd(m_cs));
        check({tag, ".digits"}, {s_tens, s_ones, cs_tens, cs_ones}, to_bcd(m_cs));
        check({tag, ".tick"}, {15'd0, tick}, {15'd0, m_tick});
        check({tag, ".wrap"}, {15'd0, wrap}, {15'd0, m_wrap});
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input string tag, input bit ini, input bit en);
        init_regs = ini;
        count_enabled = en;
        @(posedge clk);
        cyc++;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (ini) begin
            model_clear();
        end else if (en) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_tick = 1'b1;
                m_cs = (m_cs + 1) % 10000;
                m_wrap = (m_cs == 0);
            end
        end
        #1;
        if (tick) begin
            tick_cnt++;
        end
        if (wrap) begin
            wrap_cnt++;
        end
        check_all(tag);
    endtask

    initial begin
        // 1: reset held with random inputs
        for (int i = 0; i < 2; i++) begin
            init_regs = 1'($urandom);
            count_enabled = 1'($urandom);
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        @(negedge clk);
        reset = 1'b1;
        step("rst_release", 1'b0, 1'($urandom));
        step("clear0", 1'b1, 1'b0);

        // 2: 40 enabled cycles -> 00.10, ticks 4 apart
        tick_cnt = 0;
        last_tick_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            step("run40", 1'b0, 1'b1);
            if (tick) begin
                if (last_tick_cyc >= 0) begin
                    check("tick_spacing", 16'(cyc - last_tick_cyc), 16'(TICK_DIV));
                end
                last_tick_cyc = cyc;
            end
        end
        check("run40_final", time_bcd, 16'h0010);
        check("run40_ticks", 16'(tick_cnt), 16'd10);

        // 3: pause keeps the partial tick
        step("clear3", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step("pre_pause", 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step("paused", 1'b0, 1'b0);
            check("paused_hold", time_bcd, 16'h0001);
        end
        step("resume1", 1'b0, 1'b1);
        check("resume1_val", time_bcd, 16'h0001);
        step("resume2", 1'b0, 1'b1);
        check("resume2_val", time_bcd, 16'h0002);

        // 4: count to 99.98, then wrap
        step("clear4", 1'b1, 1'b0);
        while (m_cs != 9998) step("to9998", 1'b0, 1'b1);
        check("at9998", time_bcd, 16'h9998);
        wrap_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step("wrap8", 1'b0, 1'b1);
            if (i == 3) check("at9999", time_bcd, 16'h9999);
            if (wrap) check("wrap_with_tick", {15'd0, tick}, 16'd1);
        end
        check("after_wrap", time_bcd, 16'h0000);
        check("wrap_once", 16'(wrap_cnt), 16'd1);

        // 5: init wins over enable
        step("clear5", 1'b1, 1'b0);
        while (m_cs != 123) step("to0123", 1'b0, 1'b1);
        step("to0123_part", 1'b0, 1'b1);
        check("at0123", time_bcd, 16'h0123);
        step("init_and_en", 1'b1, 1'b1);
        check("init_zero", time_bcd, 16'h0000);
        check("init_notick", {15'd0, tick}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step("post_init", 1'b0, 1'b1);
            check("post_init_zero", time_bcd, 16'h0000);
        end
        step("post_init4", 1'b0, 1'b1);
        check("post_init_first", time_bcd, 16'h0001);

        // 6: asynchronous reset mid-count
        step("clear6", 1'b1, 1'b0);
        while (m_cs != 57) step("to0057", 1'b0, 1'b1);
        step("to0057_part", 1'b0, 1'b1);
        check("at0057", time_bcd, 16'h0057);
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        #2;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step("after_async", 1'b0, 1'b1);
        check("after_async_val", time_bcd, 16'h0002);

        // 7: randomized control sequence
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
